// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit, one bit of work per clock.
//
// Signed operands are reduced to magnitudes on the start edge. The core then runs
// WIDTH unsigned steps and applies the sign fix-up on the final step:
//   - multiply: shift-add
//   - divide:   restoring shift-subtract
// A divide by zero bypasses the iteration and completes on the next cycle.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   start_i      request; sampled only in IDLE or DONE
//   op_i         00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV
//   a_i, b_i     multiplicand/dividend, multiplier/divisor
//   busy_o       high while iterating
//   done_o       one-cycle pulse, results valid
//   result_lo_o  product low half / quotient
//   result_hi_o  product high half / remainder
//   divzero_o    last op was a divide with b == 0
//   flags_o      {N, Z, C, V} of the last result (C and V are always 0)
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_lo_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             divzero_o,
    output logic [3:0]       flags_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic               div_q, div_d;       // operation is a divide
    logic               neg_q, neg_d;       // result sign sa ^ sb
    logic               dsign_q, dsign_d;   // dividend sign, applied to the remainder
    logic [WIDTH-1:0]   bmag_q, bmag_d;     // |b|
    logic [WIDTH-1:0]   hi_q, hi_d;         // partial product high / partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;         // multiplier bits / dividend-then-quotient bits
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               divz_q, divz_d;
    logic [3:0]         flags_q, flags_d;

    // Operand conditioning on the start edge
    logic               in_sa, in_sb;
    logic [WIDTH-1:0]   in_amag, in_bmag;

    assign in_sa   = op_i[0] & a_i[WIDTH-1];
    assign in_sb   = op_i[0] & b_i[WIDTH-1];
    assign in_amag = in_sa ? (~a_i + 1'b1) : a_i;
    assign in_bmag = in_sb ? (~b_i + 1'b1) : b_i;

    // Multiply step: conditionally add |b| into the high half, then shift {carry, hi, lo} right
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : {(WIDTH + 1){1'b0}});
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder and subtract when it fits.
    // The remainder is always below |b|, so the W-bit difference is exact whenever it is kept.
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_hi_nx, div_lo_nx;

    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, bmag_q});
    assign div_diff  = div_shift[WIDTH-1:0] - bmag_q;
    assign div_hi_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo_nx = {lo_q[WIDTH-2:0], div_ge};

    logic [WIDTH-1:0]   step_hi, step_lo;

    assign step_hi = div_q ? div_hi_nx : mul_hi_nx;
    assign step_lo = div_q ? div_lo_nx : mul_lo_nx;

    // Sign fix-up, applied to the outcome of the final step
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_raw = {step_hi, step_lo};
    assign prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
    assign quo_fix  = neg_q ? (~step_lo + 1'b1) : step_lo;
    assign rem_fix  = dsign_q ? (~step_hi + 1'b1) : step_hi;

    // Completion values, committed to the result registers when load_res is set
    logic               load_res;
    logic               fin_div, fin_dz;
    logic [WIDTH-1:0]   fin_lo, fin_hi;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        neg_d    = neg_q;
        dsign_d  = dsign_q;
        bmag_d   = bmag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        divz_d   = divz_q;
        flags_d  = flags_q;
        load_res = 1'b0;
        fin_div  = 1'b0;
        fin_dz   = 1'b0;
        fin_lo   = '0;
        fin_hi   = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    if (op_i[1] && (b_i == '0)) begin
                        state_d  = StDone;
                        load_res = 1'b1;
                        fin_div  = 1'b1;
                        fin_dz   = 1'b1;
                        fin_lo   = '1;
                        fin_hi   = a_i;
                    end else begin
                        state_d = StRun;
                        div_d   = op_i[1];
                        neg_d   = in_sa ^ in_sb;
                        dsign_d = in_sa;
                        bmag_d  = in_bmag;
                        hi_d    = '0;
                        lo_d    = in_amag;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = StDone;
                    load_res = 1'b1;
                    fin_div  = div_q;
                    if (div_q) begin
                        fin_lo = quo_fix;
                        fin_hi = rem_fix;
                    end else begin
                        fin_lo = prod_fix[WIDTH-1:0];
                        fin_hi = prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_res) begin
            res_lo_d = fin_lo;
            res_hi_d = fin_hi;
            divz_d   = fin_dz;
            flags_d  = {fin_div ? fin_lo[WIDTH-1] : fin_hi[WIDTH-1],
                        fin_div ? (fin_lo == '0) : ((fin_lo == '0) && (fin_hi == '0)),
                        2'b00};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            dsign_q  <= 1'b0;
            bmag_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            divz_q   <= 1'b0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            dsign_q  <= dsign_d;
            bmag_q   <= bmag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            divz_q   <= divz_d;
            flags_q  <= flags_d;
        end
    end

    assign busy_o      = (state_q == StRun);
    assign done_o      = (state_q == StDone);
    assign result_lo_o = res_lo_q;
    assign result_hi_o = res_hi_q;
    assign divzero_o   = divz_q;
    assign flags_o     = flags_q;

endmodule
